trng_word_assembler: RTL and testbench
======================================

// Module: trng_word_assembler
// PURPOSE
//  Consumer end of the ring-generator serial output. Samples the 1-bit
//  whitened stream, runs a repetition-count health test on it and packs
//  WORD_W samples into a word. Each word goes to a downstream FIFO/AXI
//  reader through a valid/ready handshake.
// PARAMETERS
//  WORD_W      32  bits per output word (>=2)
//  DECIM        4  sample bit_in once every DECIM clk cycles (>=1; 1 = every cycle)
//  RCT_CUTOFF  32  run of identical consecutive samples that declares failure (>=2)
// PORTS
//  clk         in   1       clock
//  rst         in   1       reset, asynchronous, active-high
//  en          in   1       collection enable
//  bit_in      in   1       serial stream from ring generator bit_out
//  out_data    out  WORD_W  assembled word; first sample in MSB, last sample in LSB
//  out_valid   out  1       out_data holds an unconsumed word
//  out_ready   in   1       downstream accepts word when out_valid&&out_ready
//  health_clr  in   1       leave FAIL; otherwise clears overflow
//  health_fail out  1       sticky: repetition-count test tripped
//  overflow    out  1       sticky: completed word dropped due to backpressure
// BEHAVIOUR
//  Reset: all counters=0, shift reg=0, out_data=0, out_valid=0, health_fail=0,
//   overflow=0, run tracker empty (no previous bit). State=IDLE.
//  States: IDLE (en=0), COLLECT (en=1), FAIL (health_fail=1).
//   IDLE->COLLECT when en=1. COLLECT->IDLE when en=0. Any->FAIL on RCT trip.
//   FAIL->IDLE on health_clr (next cycle: counters and run tracker cleared).
//  IDLE: decim_cnt, bit_cnt, run tracker cleared; partial word discarded.
//   Pending out_data/out_valid are unaffected and still drain normally.
//  Sampling: in COLLECT, decim_cnt counts 0..DECIM-1 and wraps. Sample strobe fires
//   when decim_cnt==DECIM-1. The first strobe occurs DECIM cycles after entering COLLECT.
//  On strobe: sreg <= {sreg[WORD_W-2:0],bit_in}; bit_cnt++.
//   When bit_cnt==WORD_W-1 the word is complete and bit_cnt wraps to 0.
//  Word load: on completion, if !out_valid || out_ready (same cycle), then
//   out_data <= {sreg[WORD_W-2:0],bit_in} and out_valid=1 from the next cycle.
//   Latency is 1 clk from the last sample. Otherwise the word is dropped and overflow<=1.
//  Handshake: out_data is stable while out_valid=1 and !out_ready.
//   A transfer clears out_valid next cycle unless a new word loads in the same cycle;
//   in that case out_valid stays 1 with the new data, giving back-to-back transfers.
//  RCT: on each strobe, if the tracker is empty or bit_in != last, run_len=1;
//   otherwise run_len++, saturating at RCT_CUTOFF. The strobe on which run_len
//   reaches RCT_CUTOFF enters FAIL. health_fail=1 and out_valid=0 from the next cycle.
//   The pending word is invalidated, the partial word is discarded, and no loads occur.
//   The word completing on the tripping strobe is not loaded.
//  health_clr: in FAIL returns to IDLE and clears health_fail; overflow is untouched.
//   In IDLE/COLLECT it clears overflow. If a trip and health_clr occur in the same
//   cycle, FAIL wins and health_fail=1.
//  If overflow set and health_clr coincide, set wins.
//  Async rst mid-word or mid-handshake: immediate return to reset values.
//   The partial word is lost.
// TESTING
//  1 DECIM=1, en=1, bit_in alternating 1,0,... -> out_data=32'hAAAAAAAA, out_valid
//    rises 1 clk after 32nd sample, health_fail=0.
//  2 DECIM=4, bit_in held 4 clk per value, alternating 0,1 -> one sample per value;
//    out_data=32'h55555555 after 128 clk.
//  3 out_ready=0, two full words streamed -> first word held stable, second
//    dropped, overflow=1; health_clr pulse -> overflow=0, first word still valid.
//  4 out_ready=1 always, DECIM=1 -> out_valid stays high across word boundaries
//    with one transfer every 32 clk; no overflow.
//  5 DECIM=1, bit_in=0 for 32 samples with a word pending -> health_fail=1 and
//    out_valid=0 cycle after 32nd sample; health_clr -> IDLE, fresh word of 32 new bits.
//  6 en dropped after 10 samples (or rst asserted) -> next word built from 32
//    fresh samples only; rst mid-word forces all outputs to 0 immediately.

Source files
------------

// File: rtl/trng_word_assembler.sv
// trng_word_assembler
//   Takes the 1-bit whitened stream from the ring generator and turns it into
//   words. It samples the stream once every DECIM clocks and runs a
//   repetition-count health test on the samples. It packs WORD_W samples into
//   one word, with the first sample in the MSB. Each finished word is handed
//   downstream through a valid/ready handshake.
//
// Ports
//   clk          clock
//   rst          asynchronous, active-high reset
//   en           collection enable (IDLE <-> COLLECT)
//   bit_in       serial sample stream
//   out_data     assembled word, held stable while out_valid && !out_ready
//   out_valid    out_data holds an unconsumed word
//   out_ready    downstream accepts the word when out_valid && out_ready
//   health_clr   in FAIL: return to IDLE; otherwise: clear overflow
//   health_fail  sticky, repetition-count test tripped (state is FAIL)
//   overflow     sticky, a completed word was dropped because of backpressure
module trng_word_assembler #(
    parameter int WORD_W     = 32,
    parameter int DECIM      = 4,
    parameter int RCT_CUTOFF = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              bit_in,
    output logic [WORD_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    input  logic              health_clr,
    output logic              health_fail,
    output logic              overflow
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int BW = $clog2(WORD_W);
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    localparam logic [DW-1:0] DECIM_LAST = DW'(DECIM - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(WORD_W - 1);
    localparam logic [RW-1:0] RUN_MAX    = RW'(RCT_CUTOFF);

    typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_FAIL} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [DW-1:0]       r_decim_cnt;
    logic [BW-1:0]       r_bit_cnt;
    // The oldest sample is never read again once the word is complete, so the
    // shift register keeps only WORD_W-1 samples. The newest sample is
    // concatenated on at load time.
    logic [WORD_W-2:0]   r_sreg;
    logic                r_run_valid;
    logic                r_last_bit;
    logic [RW-1:0]       r_run_len;
    logic [WORD_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_overflow;

    logic                w_strobe;
    logic [WORD_W-1:0]   w_word;
    logic                w_complete;
    logic                w_repeat;
    logic [RW-1:0]       w_run_next;
    logic                w_trip;
    logic                w_load;
    logic                w_drop;

    // ------------------------------------------------------------------
    // Sampling, health test and load decisions
    // ------------------------------------------------------------------
    always_comb begin
        w_strobe   = (r_state == S_COLLECT) && (r_decim_cnt == DECIM_LAST);
        w_word     = {r_sreg, bit_in};
        w_complete = w_strobe && (r_bit_cnt == BIT_LAST);
        w_repeat   = r_run_valid && (bit_in == r_last_bit);
        if (!w_repeat)
            w_run_next = RW'(1);
        else if (r_run_len == RUN_MAX)
            w_run_next = RUN_MAX;
        else
            w_run_next = r_run_len + RW'(1);
        w_trip = w_strobe && (w_run_next == RUN_MAX);
        // A word that completes on the tripping strobe is thrown away silently.
        // That is a health event, not backpressure, so overflow is not set.
        w_load = w_complete && !w_trip && (!r_out_valid || out_ready);
        w_drop = w_complete && !w_trip && r_out_valid && !out_ready;
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state is updated with <= so every flop samples pre-edge values.
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        // NOTE: the default first keeps every path assigned, so no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (en) w_state_next = S_COLLECT;
            S_COLLECT: begin
                if (w_trip)
                    w_state_next = S_FAIL;
                else if (!en)
                    w_state_next = S_IDLE;
            end
            S_FAIL:    if (health_clr) w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Collection datapath: counters, shift register, run tracker.
    // Outside COLLECT, and on a trip, the partial word and the run history
    // are discarded so that the next word is built only from fresh samples.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_decim_cnt <= '0;
            r_bit_cnt   <= '0;
            r_sreg      <= '0;
            r_run_valid <= 1'b0;
            r_last_bit  <= 1'b0;
            r_run_len   <= '0;
        end else if (r_state != S_COLLECT || w_trip) begin
            r_decim_cnt <= '0;
            r_bit_cnt   <= '0;
            r_sreg      <= '0;
            r_run_valid <= 1'b0;
            r_last_bit  <= 1'b0;
            r_run_len   <= '0;
        end else begin
            r_decim_cnt <= (r_decim_cnt == DECIM_LAST) ? '0 : r_decim_cnt + DW'(1);
            if (w_strobe) begin
                r_sreg      <= w_word[WORD_W-2:0];
                r_bit_cnt   <= w_complete ? '0 : r_bit_cnt + BW'(1);
                r_run_valid <= 1'b1;
                r_last_bit  <= bit_in;
                r_run_len   <= w_run_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output word register and sticky overflow
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_trip) begin
                r_out_valid <= 1'b0;
            end else if (w_load) begin
                // A load in the same cycle as a transfer keeps valid high (back-to-back).
                r_out_data  <= w_word;
                r_out_valid <= 1'b1;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end

            // If a set and a clear happen in the same cycle, the set wins.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (health_clr && r_state != S_FAIL)
                r_overflow <= 1'b0;
        end
    end

    assign out_data    = r_out_data;
    assign out_valid   = r_out_valid;
    assign overflow    = r_overflow;
    assign health_fail = (r_state == S_FAIL);

endmodule

// File: tb/tb_trng_word_assembler.sv
module tb_trng_word_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // Instance A: DECIM=1
    logic        a_en = 1'b0, a_bit = 1'b0, a_ready = 1'b0, a_clr = 1'b0;
    logic [31:0] a_data;
    logic        a_valid, a_fail, a_ovf;

    // Instance B: DECIM=4
    logic        b_en = 1'b0, b_bit = 1'b0, b_ready = 1'b0, b_clr = 1'b0;
    logic [31:0] b_data;
    logic        b_valid, b_fail, b_ovf;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [31:0] W1   = 32'h0F0F1E1E;
    localparam logic [31:0] W2   = 32'h12345678;
    localparam logic [31:0] W3   = 32'h96C3A55B;
    localparam logic [31:0] W4   = 32'h2D4B9AC6;
    localparam logic [31:0] W5   = 32'hDEADBEEF;
    localparam logic [31:0] W6   = 32'h3C5A96F0;
    localparam logic [31:0] W7   = 32'h6B6B6B6B;
    localparam logic [31:0] JUNK = 32'hB2C00000;

    trng_word_assembler #(.WORD_W(32), .DECIM(1), .RCT_CUTOFF(32)) u_dut_a (
        .clk(clk), .rst(rst), .en(a_en), .bit_in(a_bit),
        .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready),
        .health_clr(a_clr), .health_fail(a_fail), .overflow(a_ovf)
    );

    trng_word_assembler #(.WORD_W(32), .DECIM(4), .RCT_CUTOFF(32)) u_dut_b (
        .clk(clk), .rst(rst), .en(b_en), .bit_in(b_bit),
        .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready),
        .health_clr(b_clr), .health_fail(b_fail), .overflow(b_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present w[31-from] .. w[31-to] (MSB first) to instance A, one per clock.
    task automatic send_bits(input logic [31:0] w, input int from, input int to);
        for (int i = from; i <= to; i++) begin
            a_bit = w[31-i];
            tick();
        end
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_valid", {31'd0, a_valid}, 32'd0);
        chk("rst_data",  a_data, 32'd0);
        chk("rst_fail",  {31'd0, a_fail}, 32'd0);
        chk("rst_ovf",   {31'd0, a_ovf}, 32'd0);
        chk("rst_b_data", b_data, 32'd0);
        rst = 1'b0;
        tick();

        // ---------------- 1: alternating 1,0 at DECIM=1 ----------------
        a_en = 1'b1;
        tick();
        send_bits(32'hAAAAAAAA, 0, 30);
        chk("t1_valid_before_last", {31'd0, a_valid}, 32'd0);
        send_bits(32'hAAAAAAAA, 31, 31);
        chk("t1_valid", {31'd0, a_valid}, 32'd1);
        chk("t1_data",  a_data, 32'hAAAAAAAA);
        chk("t1_fail",  {31'd0, a_fail}, 32'd0);

        // ---------------- 3: backpressure -> overflow ----------------
        send_bits(W2, 0, 15);
        chk("t3_hold_mid", a_data, 32'hAAAAAAAA);
        send_bits(W2, 16, 31);
        chk("t3_hold_data",  a_data, 32'hAAAAAAAA);
        chk("t3_hold_valid", {31'd0, a_valid}, 32'd1);
        chk("t3_ovf_set",    {31'd0, a_ovf}, 32'd1);
        a_en = 1'b0;
        tick();
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("t3_ovf_clr",    {31'd0, a_ovf}, 32'd0);
        chk("t3_still_valid", {31'd0, a_valid}, 32'd1);
        chk("t3_still_data", a_data, 32'hAAAAAAAA);

        // ---------------- 4: ready high, word boundaries ----------------
        a_ready = 1'b1;
        tick();
        chk("t4_drained", {31'd0, a_valid}, 32'd0);
        a_en = 1'b1;
        tick();
        send_bits(W1, 0, 31);
        chk("t4_w1_valid", {31'd0, a_valid}, 32'd1);
        chk("t4_w1_data",  a_data, W1);
        send_bits(W2, 0, 0);
        chk("t4_w1_taken", {31'd0, a_valid}, 32'd0);
        send_bits(W2, 1, 31);
        chk("t4_w2_valid", {31'd0, a_valid}, 32'd1);
        chk("t4_w2_data",  a_data, W2);
        // Hold W2 and then release it on the same edge that W3 completes.
        a_ready = 1'b0;
        send_bits(W3, 0, 30);
        chk("t4_w2_held", a_data, W2);
        a_ready = 1'b1;
        send_bits(W3, 31, 31);
        chk("t4_b2b_valid", {31'd0, a_valid}, 32'd1);
        chk("t4_b2b_data",  a_data, W3);
        chk("t4_no_ovf",    {31'd0, a_ovf}, 32'd0);

        // ---------------- 5: 32 zeros with a word pending -> FAIL ----------------
        a_ready = 1'b0;
        send_bits(32'h00000000, 0, 30);
        chk("t5_pre_fail",  {31'd0, a_fail}, 32'd0);
        chk("t5_pre_valid", {31'd0, a_valid}, 32'd1);
        send_bits(32'h00000000, 31, 31);
        chk("t5_fail",        {31'd0, a_fail}, 32'd1);
        chk("t5_valid_dropped", {31'd0, a_valid}, 32'd0);
        chk("t5_no_ovf",      {31'd0, a_ovf}, 32'd0);
        tick();
        chk("t5_fail_sticky", {31'd0, a_fail}, 32'd1);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("t5_fail_clr", {31'd0, a_fail}, 32'd0);
        tick();
        chk("t5_idle_valid", {31'd0, a_valid}, 32'd0);
        send_bits(W5, 0, 30);
        chk("t5_fresh_partial", {31'd0, a_valid}, 32'd0);
        send_bits(W5, 31, 31);
        chk("t5_fresh_valid", {31'd0, a_valid}, 32'd1);
        chk("t5_fresh_data",  a_data, W5);

        // ---------------- 6: en dropped mid-word ----------------
        a_en    = 1'b0;
        a_ready = 1'b1;
        tick();
        chk("t6_drained", {31'd0, a_valid}, 32'd0);
        a_ready = 1'b0;
        a_en    = 1'b1;
        tick();
        send_bits(JUNK, 0, 9);
        a_en = 1'b0;
        tick();
        a_en = 1'b1;
        tick();
        send_bits(W6, 0, 30);
        chk("t6_partial", {31'd0, a_valid}, 32'd0);
        send_bits(W6, 31, 31);
        chk("t6_valid", {31'd0, a_valid}, 32'd1);
        chk("t6_data",  a_data, W6);

        // ---------------- 6b: async reset mid-word ----------------
        send_bits(W7, 0, 4);
        rst = 1'b1;
        #2;
        chk("t6_rst_valid", {31'd0, a_valid}, 32'd0);
        chk("t6_rst_data",  a_data, 32'd0);
        chk("t6_rst_fail",  {31'd0, a_fail}, 32'd0);
        chk("t6_rst_ovf",   {31'd0, a_ovf}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        send_bits(W7, 0, 30);
        chk("t6_post_rst_partial", {31'd0, a_valid}, 32'd0);
        send_bits(W7, 31, 31);
        chk("t6_post_rst_data", a_data, W7);
        a_en = 1'b0;

        // ---------------- 2: DECIM=4, each value held 4 clk ----------------
        b_en = 1'b1;
        tick();
        for (int i = 0; i < 31; i++) begin
            b_bit = i[0];
            repeat (4) tick();
        end
        b_bit = 1'b1;
        repeat (3) tick();
        chk("t2_valid_early", {31'd0, b_valid}, 32'd0);
        tick();
        chk("t2_valid", {31'd0, b_valid}, 32'd1);
        chk("t2_data",  b_data, 32'h55555555);
        chk("t2_fail",  {31'd0, b_fail}, 32'd0);
        chk("t2_ovf",   {31'd0, b_ovf}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
